// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the I/D unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_RESP} arb_state_t;
    typedef enum logic {GNT_I, GNT_D} arb_gnt_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } arb_req_t;

    function automatic logic word_in_range(input logic [31:0] addr, input int unsigned words);
        return {2'b00, addr[31:2]} < words;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter_pick2.sv
// Combinational 2-way picker: round-robin or fixed D priority on conflict.
module arb_pick2
    import mem_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       req_i,
    input  logic       req_d,
    input  arb_gnt_t   last_grant,
    input  logic [1:0] mask,
    output logic       gnt_valid,
    output arb_gnt_t   gnt
);

    logic cand_i;
    logic cand_d;

    // mask[0] excludes I, mask[1] excludes D
    assign cand_i = req_i && !mask[0];
    assign cand_d = req_d && !mask[1];

    always_comb begin
        gnt_valid = cand_i || cand_d;
        gnt       = GNT_I;
        if (cand_i && cand_d) begin
            if (RR_EN)
                gnt = (last_grant == GNT_I) ? GNT_D : GNT_I;
            else
                gnt = GNT_D;
        end else if (cand_d) begin
            gnt = GNT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port memory between fetch (I) and load/store (D).
// Optional perf counters are enabled with the MEM_ARB_PERF_EN macro.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter bit          RR_EN     = 1'b1,
    parameter int unsigned MEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_byte_enable,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_i_cnt,
    output logic [31:0] perf_d_cnt,
    output logic [31:0] perf_conflict_cnt
`endif
);

    arb_state_t  state, next_state;
    arb_gnt_t    winner;
    arb_gnt_t    pick_gnt;
    arb_req_t    lat;
    arb_req_t    sel_req;
    logic        pick_valid;
    logic        arb_go;
    logic [1:0]  pick_mask;
    logic        lat_bad;
    logic [31:0] resp_data;

    // In RESP the winner still holds req for its ack cycle, so it is masked out
    always_comb begin
        pick_mask = 2'b00;
        if (state == ARB_RESP)
            pick_mask = (winner == GNT_D) ? 2'b10 : 2'b01;
    end

    arb_pick2 #(.RR_EN(RR_EN)) u_pick (
        .req_i      (i_req),
        .req_d      (d_req),
        .last_grant (winner),
        .mask       (pick_mask),
        .gnt_valid  (pick_valid),
        .gnt        (pick_gnt)
    );

    assign arb_go = pick_valid && (state == ARB_IDLE || state == ARB_RESP);

    always_comb begin
        sel_req = '0;
        if (pick_gnt == GNT_D) begin
            sel_req.addr  = d_addr;
            sel_req.wdata = d_wdata;
            sel_req.be    = d_be;
            sel_req.we    = d_we;
        end else begin
            sel_req.addr  = i_addr;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE:   if (pick_valid) next_state = ARB_ACCESS;
            ARB_ACCESS: next_state = ARB_RESP;
            ARB_RESP:   next_state = pick_valid ? ARB_ACCESS : ARB_IDLE;
            default:    next_state = ARB_IDLE;
        endcase
    end

    assign lat_bad   = !word_in_range(lat.addr, MEM_WORDS) ||
                       (lat.we && (lat.addr[1:0] != 2'b00));
    assign resp_data = lat_bad ? '0 : mem_read_data;

    assign mem_address      = lat.addr;
    assign mem_write_data   = lat.wdata;
    assign mem_byte_enable  = lat.be;
    // Gated by rst_n so a reset landing on ACCESS cannot commit the store
    assign mem_write_enable = rst_n && (state == ARB_ACCESS) && lat.we && !lat_bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ARB_IDLE;
            winner  <= GNT_I;
            lat     <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
            d_err   <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            state <= next_state;
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            d_err <= 1'b0;
            if (arb_go) begin
                lat    <= sel_req;
                winner <= pick_gnt;
            end
            if (state == ARB_ACCESS) begin
                if (winner == GNT_D) begin
                    d_ack   <= 1'b1;
                    d_err   <= lat_bad;
                    d_rdata <= resp_data;
                end else begin
                    i_ack   <= 1'b1;
                    i_rdata <= resp_data;
                end
            end
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic both_wait;

    // Outside RESP, both reqs high means one of them is genuinely stalled
    assign both_wait = i_req && d_req && (state != ARB_RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_i_cnt        <= '0;
            perf_d_cnt        <= '0;
            perf_conflict_cnt <= '0;
        end else begin
            if (arb_go && pick_gnt == GNT_I) perf_i_cnt <= sat_inc(perf_i_cnt);
            if (arb_go && pick_gnt == GNT_D) perf_d_cnt <= sat_inc(perf_d_cnt);
            if (both_wait) perf_conflict_cnt <= sat_inc(perf_conflict_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner sequences, random traffic.
module tb_mem_arbiter;

    localparam int unsigned MEM_WORDS = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_byte_enable;
    logic        mem_write_enable;
    logic [31:0] mem_read_data;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];

    mem_arbiter #(.RR_EN(1'b1), .MEM_WORDS(MEM_WORDS)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_req            (i_req),
        .i_addr           (i_addr),
        .i_ack            (i_ack),
        .i_rdata          (i_rdata),
        .d_req            (d_req),
        .d_we             (d_we),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_be             (d_be),
        .d_ack            (d_ack),
        .d_rdata          (d_rdata),
        .d_err            (d_err),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_byte_enable  (mem_byte_enable),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    always #5 clk = ~clk;

    // Out-of-range reads return a poison word the arbiter must suppress
    assign mem_read_data = ({2'b00, mem_address[31:2]} < MEM_WORDS) ?
                           mem[mem_address[8:2]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (mem_write_enable) begin
            we_cnt = we_cnt + 1;
            for (int b = 0; b < 4; b++)
                if (mem_byte_enable[b])
                    mem[mem_address[8:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
        end
    end

    always @(negedge clk) begin
        if (i_ack || d_ack) begin
            checks = checks + 1;
            if (i_ack && d_ack) begin
                errors = errors + 1;
                $display("FAIL dual_ack at %0t: i_ack=%b d_ack=%b required not both", $time, i_ack, d_ack);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_lat_max(input string name, input int lat, input int maxlat);
        checks = checks + 1;
        if (lat < 1 || lat > maxlat) begin
            errors = errors + 1;
            $display("FAIL %s latency actual=%0d required 1..%0d", name, lat, maxlat);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic d_xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err,
                          output int lat);
        @(negedge clk);
        d_we = we; d_addr = addr; d_wdata = wdata; d_be = be; d_req = 1'b1;
        lat = -1; rdata = '0; err = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (d_ack) begin
                lat = n; rdata = d_rdata; err = d_err;
                break;
            end
        end
        d_req = 1'b0;
    endtask

    task automatic i_xact(input logic [31:0] addr, output logic [31:0] rdata, output int lat);
        @(negedge clk);
        i_addr = addr; i_req = 1'b1;
        lat = -1; rdata = '0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (i_ack) begin
                lat = n; rdata = i_rdata;
                break;
            end
        end
        i_req = 1'b0;
    endtask

    // Reference: a store lands only when aligned and in range; bad accesses read as 0
    function automatic void ref_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] be, output logic [31:0] er, output logic ee,
                                  output logic chk_data);
        int unsigned idx = addr >> 2;
        er = '0; ee = 1'b0; chk_data = 1'b1;
        if (idx >= MEM_WORDS || (we && addr[1:0] != 2'b00)) begin
            ee = 1'b1;
        end else if (we) begin
            chk_data = 1'b0;
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            er = ref_mem[idx];
        end
    endfunction

    function automatic logic [31:0] ref_i(input logic [31:0] addr);
        int unsigned idx = addr >> 2;
        return (idx < MEM_WORDS) ? ref_mem[idx] : 32'h0;
    endfunction

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        chk_data;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_wr;
    } dvec_t;

    dvec_t vt[13];

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          w0;
        int          n_acks;
        int          saw_ack;
        int          ack_cyc[4];
        logic        ack_isd[4];
        logic [31:0] ack_data[4];

        vt[0]  = '{1'b1, 32'h10,       32'h1122_3344, 4'b0011, 1'b0, 32'h0,          1'b0, 1};
        vt[1]  = '{1'b0, 32'h10,       32'h0,         4'b0000, 1'b1, 32'h0000_3344,  1'b0, 0};
        vt[2]  = '{1'b1, 32'h12,       32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h0,          1'b1, 0};
        vt[3]  = '{1'b0, 32'h13,       32'h0,         4'b0000, 1'b1, 32'h0000_3344,  1'b0, 0};
        vt[4]  = '{1'b1, 32'h200,      32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h0,          1'b1, 0};
        vt[5]  = '{1'b0, 32'h200,      32'h0,         4'b0000, 1'b1, 32'h0,          1'b1, 0};
        vt[6]  = '{1'b1, 32'h1FC,      32'hAB00_0000, 4'b1000, 1'b0, 32'h0,          1'b0, 1};
        vt[7]  = '{1'b0, 32'h1FC,      32'h0,         4'b0000, 1'b1, 32'hAB00_0000,  1'b0, 0};
        vt[8]  = '{1'b1, 32'h10,       32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0,          1'b0, 1};
        vt[9]  = '{1'b0, 32'h10,       32'h0,         4'b0000, 1'b1, 32'h0000_3344,  1'b0, 0};
        vt[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,        4'b0000, 1'b1, 32'h0,          1'b1, 0};
        vt[11] = '{1'b1, 32'h14,       32'h5566_0000, 4'b1100, 1'b0, 32'h0,          1'b0, 1};
        vt[12] = '{1'b0, 32'h14,       32'h0,         4'b0000, 1'b1, 32'h5566_0000,  1'b0, 0};

        for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= '0;
        mem[2] <= 32'hDEAD_BEEF;
        mem[1] <= 32'h1234_5678;

        // Reset values
        do_reset();
        chk("rst_i_ack", {31'd0, i_ack}, 32'd0);
        chk("rst_d_ack", {31'd0, d_ack}, 32'd0);
        chk("rst_d_err", {31'd0, d_err}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        chk("rst_mem_be", {28'd0, mem_byte_enable}, 32'd0);

        // Plain fetch
        i_xact(32'h8, rd, lat);
        chk("fetch_rdata", rd, 32'hDEAD_BEEF);
        chk("fetch_latency", lat, 2);

        // Data-side vector table
        for (int i = 0; i < 13; i++) begin
            w0 = we_cnt;
            d_xact(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, rd, er, lat);
            chk($sformatf("vec%0d_latency", i), lat, 2);
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vt[i].exp_err});
            if (vt[i].chk_data) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
            chk($sformatf("vec%0d_writes", i), we_cnt - w0, vt[i].exp_wr);
        end
        chk("mem4_after_table", mem[4], 32'h0000_3344);

        // Fetch out of range reads as zero, never writes
        w0 = we_cnt;
        i_xact(MEM_WORDS * 4, rd, lat);
        chk("fetch_oor_rdata", rd, 32'd0);
        chk("fetch_oor_writes", we_cnt - w0, 0);

        // Conflict from reset: D, I, D, I with acks two cycles apart
        @(negedge clk);
        rst_n = 1'b0;
        i_addr = 32'h8; i_req = 1'b1;
        d_addr = 32'h4; d_we = 1'b0; d_be = '0; d_wdata = '0; d_req = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_acks = 0;
        for (int c = 1; c <= 30 && n_acks < 4; c++) begin
            @(negedge clk);
            if (i_ack || d_ack) begin
                ack_cyc[n_acks]  = c;
                ack_isd[n_acks]  = d_ack;
                ack_data[n_acks] = d_ack ? d_rdata : i_rdata;
                n_acks++;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        chk("conflict_ack_count", n_acks, 4);
        for (int k = 0; k < n_acks; k++) begin
            chk($sformatf("conflict%0d_is_d", k), {31'd0, ack_isd[k]}, {31'd0, (k % 2 == 0)});
            chk($sformatf("conflict%0d_cycle", k), ack_cyc[k], 2 + 2 * k);
            chk($sformatf("conflict%0d_data", k), ack_data[k],
                (k % 2 == 0) ? 32'h1234_5678 : 32'hDEAD_BEEF);
        end
        repeat (2) @(negedge clk);

        // Reset landing on the ACCESS cycle of a store
        w0 = we_cnt;
        saw_ack = 0;
        @(negedge clk);
        d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hCAFE_F00D; d_be = 4'hF; d_req = 1'b1;
        @(negedge clk);
        rst_n = 1'b0; d_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (i_ack || d_ack) saw_ack++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (i_ack || d_ack) saw_ack++;
        end
        chk("midrst_no_ack", saw_ack, 0);
        chk("midrst_no_write", we_cnt - w0, 0);
        chk("midrst_mem8", mem[8], 32'd0);
        d_xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        chk("midrst_recover_latency", lat, 2);
        chk("midrst_recover_rdata", rd, 32'd0);

        // Random concurrent traffic: I reads words 0..63, D owns words 64..127
        @(negedge clk);
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            logic [31:0] v;
            v = $urandom;
            mem[i] <= v;
            ref_mem[i] = v;
        end
        fork
            begin
                for (int t = 0; t < 80; t++) begin
                    logic [31:0] a, r;
                    int l;
                    if ($urandom_range(0, 9) == 0) a = 32'h200 + 32'($urandom_range(0, 4095));
                    else a = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
                    i_xact(a, r, l);
                    chk($sformatf("rnd_i%0d_rdata", t), r, ref_i(a));
                    chk_lat_max($sformatf("rnd_i%0d", t), l, 4);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin
                for (int t = 0; t < 80; t++) begin
                    logic [31:0] a, wd, r, er_exp;
                    logic [3:0]  be;
                    logic        we, e, ee, cd;
                    int l;
                    if ($urandom_range(0, 9) == 0) a = 32'h200 + 32'($urandom_range(0, 4095));
                    else a = {23'd0, 1'b1, 6'($urandom_range(0, 63)), 2'b00};
                    if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
                    we = 1'($urandom_range(0, 1));
                    wd = $urandom;
                    be = 4'($urandom_range(0, 15));
                    d_xact(we, a, wd, be, r, e, l);
                    ref_d(we, a, wd, be, er_exp, ee, cd);
                    chk($sformatf("rnd_d%0d_err", t), {31'd0, e}, {31'd0, ee});
                    if (cd) chk($sformatf("rnd_d%0d_rdata", t), r, er_exp);
                    chk_lat_max($sformatf("rnd_d%0d", t), l, 4);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join
        repeat (2) @(negedge clk);
        begin
            int diffs = 0;
            for (int i = 0; i < int'(MEM_WORDS); i++)
                if (mem[i] !== ref_mem[i]) diffs++;
            chk("rnd_final_mem_diffs", diffs, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=expired required=finish");
        $fatal(1, "timeout");
    end

endmodule
